return_addr_stack: RTL

Return-address stack for the jump path of the MIPS datapath. It is the reader counterpart to the jump-offset register: a jump-and-link pushes its link address, and a jump-register return pops it back out. The stored value is offset-relative, so a return taken after the jump-offset register has been rewritten resolves against the current offset. It sits beside the jump-offset register and feeds the PC-select mux with a registered return target.

---
 rtl/return_addr_stack.sv | 92 +++++++++
 1 files changed

// File: rtl/return_addr_stack.sv
// Return-address stack holding offset-relative link addresses; pops rebase onto the current jump offset.
// RAS_OVERFLOW_WRAP_EN: when defined, a push while full overwrites the oldest entry instead of being dropped.
module return_addr_stack #(
    parameter int DEPTH = 8,
    parameter int AW    = 32
) (
    input  logic                     CLK,
    input  logic                     RST,
    input  logic                     Push,
    input  logic [AW-1:0]            PushADDR,
    input  logic                     Pop,
    input  logic [AW-1:0]            JumpOffset,
    input  logic                     ClrFlags,
    output logic [AW-1:0]            ReturnADDR,
    output logic                     ReturnValid,
    output logic                     Empty,
    output logic                     Full,
    output logic [$clog2(DEPTH):0]   Count,
    output logic                     Overflow,
    output logic                     Underflow
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW:0]   FULL_COUNT = (PW+1)'(DEPTH);
    localparam logic [PW-1:0] TOP_RESET  = PW'(DEPTH - 1);
`ifdef RAS_OVERFLOW_WRAP_EN
    localparam bit WRAP = 1'b1;
`else
    localparam bit WRAP = 1'b0;
`endif

    logic [AW-1:0] mem [DEPTH];
    logic [PW-1:0] top;
    logic [PW-1:0] top_inc;
    logic [PW-1:0] top_dec;
    logic [PW-1:0] wr_idx;
    logic          pop_ok;
    logic          pop_unf;
    logic          push_wr;
    logic          push_drop;
    logic          push_only;

    assign Empty = (Count == '0);
    assign Full  = (Count == FULL_COUNT);

    always_comb begin
        top_inc   = top + 1'b1;
        top_dec   = top - 1'b1;
        pop_ok    = Pop && !Empty;
        pop_unf   = Pop && Empty;
        push_only = Push && !pop_ok;
        // A push paired with a successful pop replaces the top slot in place.
        push_wr   = Push && (pop_ok || !Full || WRAP);
        push_drop = push_only && Full && !WRAP;
        wr_idx    = pop_ok ? top : top_inc;
    end

    always_ff @(posedge CLK) begin
        if (push_wr) begin
            mem[wr_idx] <= PushADDR - JumpOffset;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            top         <= TOP_RESET;
            Count       <= '0;
            ReturnADDR  <= '0;
            ReturnValid <= 1'b0;
            Overflow    <= 1'b0;
            Underflow   <= 1'b0;
        end else begin
            ReturnValid <= pop_ok;
            if (pop_ok) begin
                ReturnADDR <= mem[top] + JumpOffset;
            end
            if (pop_ok && !Push) begin
                top   <= top_dec;
                Count <= Count - 1'b1;
            end else if (push_only && !Full) begin
                top   <= top_inc;
                Count <= Count + 1'b1;
            end else if (push_only && Full && WRAP) begin
                top <= top_inc;
            end
            // New events win over a simultaneous clear.
            Overflow  <= (Overflow  && !ClrFlags) || push_drop;
            Underflow <= (Underflow && !ClrFlags) || pop_unf;
        end
    end

endmodule
